// File: rtl/logic_gate_pkg.sv
// Shared definitions for the logic gate unit: op encoding and result-entry sizing.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_RSVD = 3'd7
    } gate_op_e;

    // One buffered result: {y lanes, y_any per lane, op_err}.
    function automatic int entry_width(input int width, input int channels);
        return width * channels + channels + 1;
    endfunction

endpackage

// File: rtl/logic_gate_unit_lane.sv
// Combinational evaluator for one WIDTH-bit lane of the logic gate unit.
module gate_lane
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOTA: y = ~a;
            default: y = '0;   // reserved op yields an all-zero lane
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered multi-lane bitwise gate with valid/ready handshakes,
// a 2-entry output buffer and an accepted-beat counter.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] y,
    output logic [CHANNELS-1:0]       y_any,
    output logic                      op_err,
    output logic [CNT_W-1:0]          txn_count
);

    localparam int DATA_W  = CHANNELS * WIDTH;
    localparam int ENTRY_W = entry_width(WIDTH, CHANNELS);

    logic [DATA_W-1:0]   lane_y;
    logic [CHANNELS-1:0] lane_any;
    logic [ENTRY_W-1:0]  new_entry;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            gate_lane #(.WIDTH(WIDTH)) u_lane (
                .op (op),
                .a  (a[gi*WIDTH +: WIDTH]),
                .b  (b[gi*WIDTH +: WIDTH]),
                .y  (lane_y[gi*WIDTH +: WIDTH])
            );
            assign lane_any[gi] = |lane_y[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign new_entry = {lane_y, lane_any, (op == OP_RSVD)};

    // Shift-style buffer: head_reg always drives the outputs, so the last
    // result stays visible after the buffer empties.
    logic [ENTRY_W-1:0] head_reg, head_next;
    logic [ENTRY_W-1:0] tail_reg, tail_next;
    logic [1:0]         fill_reg, fill_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               push, pop;

    assign in_ready  = (fill_reg != 2'd2);
    assign out_valid = (fill_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_next = head_reg;
        tail_next = tail_reg;
        fill_next = fill_reg;
        cnt_next  = cnt_reg + CNT_W'(push);
        case (fill_reg)
            2'd0: begin
                if (push) begin
                    head_next = new_entry;
                    fill_next = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_next = new_entry;
                end else if (push) begin
                    tail_next = new_entry;
                    fill_next = 2'd2;
                end else if (pop) begin
                    fill_next = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_next = tail_reg;
                    fill_next = 2'd1;
                end
            end
            default: fill_next = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            fill_reg <= 2'd0;
            cnt_reg  <= '0;
        end else begin
            head_reg <= head_next;
            tail_reg <= tail_next;
            fill_reg <= fill_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign y         = head_reg[ENTRY_W-1 -: DATA_W];
    assign y_any     = head_reg[1 +: CHANNELS];
    assign op_err    = head_reg[0];
    assign txn_count = cnt_reg;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: expected results are queued when a beat
// is accepted and compared when the unit hands the result downstream.
module tb_logic_gate_unit;

    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic [31:0] y;
        logic [3:0]  any;
        logic        err;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          op;
    logic [31:0]         a;
    logic [31:0]         b;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         y;
    logic [3:0]          y_any;
    logic                op_err;
    logic [TB_CNT_W-1:0] txn_count;

    exp_t                sb[$];
    exp_t                exp_next;
    logic [TB_CNT_W-1:0] cnt_model;
    int                  n_checks;
    int                  n_pass;

    logic [7:0] sweep_tab [7];

    logic_gate_unit #(.WIDTH(8), .CHANNELS(4), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_any     (y_any),
        .op_err    (op_err),
        .txn_count (txn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else begin
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            $error("%s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        case (o)
            3'd0: e.y = av & bv;
            3'd1: e.y = av | bv;
            3'd2: e.y = ~(av & bv);
            3'd3: e.y = ~(av | bv);
            3'd4: e.y = av ^ bv;
            3'd5: e.y = ~(av ^ bv);
            3'd6: e.y = ~av;
            default: e.y = 32'h0;
        endcase
        for (int i = 0; i < 4; i++) e.any[i] = |e.y[i*8 +: 8];
        e.err = (o == 3'd7);
        return e;
    endfunction

    task automatic set_beat(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
        exp_next = model(o, av, bv);
    endtask

    // One clock: check handshake levels, retire a popped result, queue an accepted beat.
    task automatic cycle();
        logic push, pop;
        exp_t e;
        chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
        push = in_valid && in_ready;
        pop  = out_valid && out_ready;
        if (pop && sb.size() != 0) begin
            e = sb.pop_front();
            $display("pop  y=%h y_any=%b op_err=%b (want y=%h y_any=%b op_err=%b)",
                     y, y_any, op_err, e.y, e.any, e.err);
            chk("y", 64'(y), 64'(e.y));
            chk("y_any", 64'(y_any), 64'(e.any));
            chk("op_err", 64'(op_err), 64'(e.err));
        end
        if (push) begin
            sb.push_back(exp_next);
            cnt_model++;
        end
        @(posedge clk);
        #1;
        chk("txn_count", 64'(txn_count), 64'(cnt_model));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        cnt_model = '0;
        sweep_tab = '{8'h24, 8'hBD, 8'hDB, 8'h42, 8'h99, 8'h66, 8'h5A};
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = 32'h0;
        b         = 32'h0;
        exp_next  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_y_any", 64'(y_any), 64'd0);
        chk("rst_op_err", 64'(op_err), 64'd0);
        chk("rst_txn_count", 64'(txn_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // NOR on mixed lanes
        out_ready = 1'b1;
        set_beat(3'd3, 32'h00FF_0F00, 32'h0000_F000);
        exp_next = '{y: 32'hFF00_00FF, any: 4'b1001, err: 1'b0};
        cycle();
        chk("nor_txn_count", 64'(txn_count), 64'd1);
        in_valid = 1'b0;
        cycle();

        // sweep ops 0..6 on A5/3C lanes, one per cycle
        for (int i = 0; i < 7; i++) begin
            set_beat(3'(i), {4{8'hA5}}, {4{8'h3C}});
            exp_next = '{y: {4{sweep_tab[i]}}, any: 4'b1111, err: 1'b0};
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // reserved op
        set_beat(3'd7, 32'hDEAD_BEEF, 32'h1234_5678);
        exp_next = '{y: 32'h0, any: 4'b0000, err: 1'b1};
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // backpressure: three beats while the consumer stalls
        out_ready = 1'b0;
        set_beat(3'd4, $urandom, $urandom);
        cycle();
        set_beat(3'd1, $urandom, $urandom);
        cycle();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        set_beat(3'd5, $urandom, $urandom);
        cycle();
        cycle();
        chk("held_txn_count", 64'(txn_count), 64'(cnt_model));
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // streaming at fill=1: push and pop together every cycle
        out_ready = 1'b0;
        set_beat(3'd2, $urandom, $urandom);
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_beat(3'($urandom_range(0, 7)), $urandom, $urandom);
            cycle();
            chk("stream_fill1", 64'(sb.size()), 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // asynchronous reset with a full buffer
        out_ready = 1'b0;
        set_beat(3'd0, $urandom, $urandom);
        cycle();
        set_beat(3'd6, 32'h0F0F_0F0F, $urandom);
        cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_y", 64'(y), 64'd0);
        chk("arst_txn_count", 64'(txn_count), 64'd0);
        sb.delete();
        cnt_model = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        cycle();

        // counter wrap: 15 beats reach the max, one more wraps to 0
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            set_beat(3'($urandom_range(0, 6)), $urandom, $urandom);
            cycle();
        end
        chk("cnt_max", 64'(txn_count), 64'hF);
        set_beat(3'd7, $urandom, $urandom);
        cycle();
        chk("cnt_wrap", 64'(txn_count), 64'd0);
        in_valid = 1'b0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
